// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
//   Consumer end of the branch-condition path. Takes a BEQZ/BNEZ request
//   from decode, resolves it with the zero-test rule, and on a taken branch
//   drives a redirect handshake to fetch followed by a wrong-path flush
//   window. Decode is stalled while a branch is unresolved, a redirect is
//   outstanding or the flush window is open. Taken/not-taken statistics
//   counters saturate at all-ones.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   br_valid/br_ready    branch request handshake (ready only in IDLE)
//   br_kind              0 = BEQZ, 1 = BNEZ
//   br_operand(_ready)   register under test and its forwarding-valid flag
//   br_pc, br_offset     branch PC and signed word offset
//   stall                hold decode/fetch
//   redirect_valid/pc    redirect request to fetch, accepted by fetch_ack
//   flush                squash wrong-path IF/ID slots
//   taken_cnt            saturating taken-branch count
//   nottaken_cnt         saturating not-taken-branch count
module branch_redirect_ctrl #(
  parameter int DATA_W       = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     br_valid,
  output logic                     br_ready,
  input  logic                     br_kind,
  input  logic [DATA_W-1:0]        br_operand,
  input  logic                     br_operand_ready,
  input  logic [DATA_W-1:0]        br_pc,
  input  logic signed [DATA_W-1:0] br_offset,
  output logic                     stall,
  output logic                     redirect_valid,
  output logic [DATA_W-1:0]        redirect_pc,
  input  logic                     fetch_ack,
  output logic                     flush,
  output logic [DATA_W-1:0]        taken_cnt,
  output logic [DATA_W-1:0]        nottaken_cnt
);

  // Flush counter runs 0 .. FLUSH_CYCLES-1; at least one bit even when unused.
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_OPND = 2'd1,
    REDIRECT  = 2'd2,
    FLUSH     = 2'd3
  } state_t;

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] x);
    return (&x) ? x : x + DATA_W'(1);
  endfunction

  function automatic logic is_taken(input logic kind, input logic [DATA_W-1:0] opnd);
    return (opnd == '0) ^ kind;
  endfunction

  // Target wraps silently modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] branch_target(input logic [DATA_W-1:0] pc,
                                                      input logic [DATA_W-1:0] off);
    return pc + DATA_W'(1) + off;
  endfunction

  state_t                     state_q, state_d;
  logic                       rv_q, rv_d;
  logic [DATA_W-1:0]          rpc_q, rpc_d;
  logic                       flush_q, flush_d;
  logic [FCW-1:0]             fcnt_q, fcnt_d;
  logic [DATA_W-1:0]          tcnt_q, tcnt_d;
  logic [DATA_W-1:0]          ncnt_q, ncnt_d;
  logic                       kind_q;
  logic [DATA_W-1:0]          pc_q;
  logic signed [DATA_W-1:0]   off_q;

  logic                       capture;
  logic                       do_resolve;
  logic                       sel_kind;
  logic [DATA_W-1:0]          sel_pc;
  logic [DATA_W-1:0]          sel_off;

  assign br_ready = (state_q == IDLE);
  assign stall    = (state_q != IDLE);

  // In IDLE the live request fields are used so a ready operand resolves
  // in the accept cycle; in WAIT_OPND the captured fields are used.
  assign capture    = (state_q == IDLE) && br_valid;
  assign sel_kind   = (state_q == IDLE) ? br_kind   : kind_q;
  assign sel_pc     = (state_q == IDLE) ? br_pc     : pc_q;
  assign sel_off    = (state_q == IDLE) ? br_offset : off_q;
  assign do_resolve = br_operand_ready &&
                      (capture || (state_q == WAIT_OPND));

  always_comb begin
    state_d = state_q;
    rv_d    = rv_q;
    rpc_d   = rpc_q;
    flush_d = flush_q;
    fcnt_d  = fcnt_q;
    tcnt_d  = tcnt_q;
    ncnt_d  = ncnt_q;
    case (state_q)
      IDLE: begin
        if (br_valid && !br_operand_ready) state_d = WAIT_OPND;
      end
      WAIT_OPND: ;
      REDIRECT: begin
        if (fetch_ack) begin
          rv_d = 1'b0;
          if (FLUSH_CYCLES > 0) begin
            state_d = FLUSH;
            flush_d = 1'b1;
            fcnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (fcnt_q == FLUSH_LAST) begin
          flush_d = 1'b0;
          state_d = IDLE;
        end else begin
          fcnt_d = fcnt_q + FCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_resolve) begin
      if (is_taken(sel_kind, br_operand)) begin
        tcnt_d  = sat_inc(tcnt_q);
        rpc_d   = branch_target(sel_pc, sel_off);
        rv_d    = 1'b1;
        state_d = REDIRECT;
      end else begin
        ncnt_d  = sat_inc(ncnt_q);
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
      flush_q <= 1'b0;
      fcnt_q  <= '0;
      tcnt_q  <= '0;
      ncnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
      flush_q <= flush_d;
      fcnt_q  <= fcnt_d;
      tcnt_q  <= tcnt_d;
      ncnt_q  <= ncnt_d;
    end
  end

  // Captured request fields: only meaningful while WAIT_OPND, so no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      kind_q <= br_kind;
      pc_q   <= br_pc;
      off_q  <= br_offset;
    end
  end

  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign flush          = flush_q;
  assign taken_cnt      = tcnt_q;
  assign nottaken_cnt   = ncnt_q;

endmodule
